sipo_deserializer: RTL and testbench



---
 rtl/sipo_deserializer_if.sv | 40 ++++
 rtl/sipo_deserializer.sv | 104 ++++++++++
 tb/tb_sipo_deserializer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// Bus bundle for the serial-in/parallel-out deserializer: serial input side,
// parallel word output with valid/ready handshake, and status signals.
interface sipo_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             din;
  logic             din_valid;
  logic             start;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;

  // Producer/consumer side that drives the serial stream and drains words
  modport master (
    output din,
    output din_valid,
    output start,
    output dout_ready,
    input  dout,
    input  dout_valid,
    input  bit_cnt,
    input  overrun
  );

  // Deserializer side
  modport slave (
    input  din,
    input  din_valid,
    input  start,
    input  dout_ready,
    output dout,
    output dout_valid,
    output bit_cnt,
    output overrun
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer. Packs a single-bit stream into
// WIDTH-bit words using a bit counter and shift register, and presents each
// completed word through a one-entry holding register with valid/ready.
// A word that completes while the holding register is still occupied and not
// being drained is dropped and flagged with a one-cycle overrun pulse.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst,
  sipo_deserializer_if.slave bus
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_next;
  logic             dout_valid_q;
  logic             dout_valid_next;
  logic             overrun_q;
  logic             overrun_next;
  logic             transfer;
  logic             free;
  logic             complete;

  // Next-state computation for the shifter, counter and holding register
  always_comb begin
    transfer        = dout_valid_q && bus.dout_ready;
    free            = !dout_valid_q || transfer;

    // A start bit shifts into a cleared register so no stale bits survive
    sr_base         = bus.start ? '0 : sr_q;
    if (MSB_FIRST) begin
      shifted = {sr_base[WIDTH-2:0], bus.din};
    end else begin
      shifted = {bus.din, sr_base[WIDTH-1:1]};
    end

    // A start bit is always bit 0, so it can never complete a word
    complete        = bus.din_valid && !bus.start && (cnt_q == LAST);

    sr_next         = sr_q;
    cnt_next        = cnt_q;
    dout_next       = dout_q;
    dout_valid_next = dout_valid_q;
    overrun_next    = 1'b0;

    if (bus.din_valid) begin
      sr_next = shifted;
      if (bus.start) begin
        cnt_next = CNT_W'(1);
      end else if (complete) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_q + 1'b1;
      end
    end else if (bus.start) begin
      sr_next  = '0;
      cnt_next = '0;
    end

    if (complete) begin
      if (free) begin
        dout_next       = shifted;
        dout_valid_next = 1'b1;
      end else begin
        overrun_next    = 1'b1;
      end
    end else if (transfer) begin
      dout_valid_next = 1'b0;
    end
  end

  // State registers with synchronous reset that overrides every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sr_q         <= sr_next;
      cnt_q        <= cnt_next;
      dout_q       <= dout_next;
      dout_valid_q <= dout_valid_next;
      overrun_q    <= overrun_next;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer. Two instances share one stimulus
// stream: one packs MSB-first, the other LSB-first. Inputs change on the
// falling edge; outputs are sampled 1ns after the rising edge.
module tb_sipo_deserializer;

  logic clk;
  logic rst;
  logic din;
  logic din_valid;
  logic start;
  logic dout_ready;

  int checks;
  int errors;

  sipo_deserializer_if #(.WIDTH(8)) bus_msb ();
  sipo_deserializer_if #(.WIDTH(8)) bus_lsb ();

  assign bus_msb.din        = din;
  assign bus_msb.din_valid  = din_valid;
  assign bus_msb.start      = start;
  assign bus_msb.dout_ready = dout_ready;
  assign bus_lsb.din        = din;
  assign bus_lsb.din_valid  = din_valid;
  assign bus_lsb.start      = start;
  assign bus_lsb.dout_ready = dout_ready;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_msb.slave)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_lsb.slave)
  );

  // 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then wait until just after the sampling edge
  task automatic applyStimulus(input logic r, input logic d, input logic v,
                               input logic s, input logic rdy);
    @(negedge clk);
    rst        = r;
    din        = d;
    din_valid  = v;
    start      = s;
    dout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Send an 8-bit word in transmission order (bit 7 first), back to back
  task automatic sendWord(input logic [7:0] w, input logic rdy_mid,
                          input logic rdy_last);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b0, w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy_mid);
    end
  endtask

  task automatic checkMsb(input string tag, input logic [7:0] d,
                          input logic v, input logic [2:0] cnt, input logic ovr);
    checkOutput({tag, "_msb_dout"}, 32'(bus_msb.dout), 32'(d));
    checkOutput({tag, "_msb_valid"}, 32'(bus_msb.dout_valid), 32'(v));
    checkOutput({tag, "_msb_cnt"}, 32'(bus_msb.bit_cnt), 32'(cnt));
    checkOutput({tag, "_msb_ovr"}, 32'(bus_msb.overrun), 32'(ovr));
  endtask

  task automatic checkLsb(input string tag, input logic [7:0] d,
                          input logic v, input logic [2:0] cnt, input logic ovr);
    checkOutput({tag, "_lsb_dout"}, 32'(bus_lsb.dout), 32'(d));
    checkOutput({tag, "_lsb_valid"}, 32'(bus_lsb.dout_valid), 32'(v));
    checkOutput({tag, "_lsb_cnt"}, 32'(bus_lsb.bit_cnt), 32'(cnt));
    checkOutput({tag, "_lsb_ovr"}, 32'(bus_lsb.overrun), 32'(ovr));
  endtask

  logic [7:0] stream;

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    din        = 1'b0;
    din_valid  = 1'b0;
    start      = 1'b0;
    dout_ready = 1'b0;

    // Reset held for two cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkMsb("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    checkLsb("reset", 8'h00, 1'b0, 3'd0, 1'b0);

    // Stream 0,0,0,1,1,1,1,1: MSB-first packs to 1F, LSB-first to F8
    stream = 8'b0001_1111;
    for (int i = 7; i >= 1; i--) begin
      applyStimulus(1'b0, stream[i], 1'b1, 1'b0, 1'b1);
      checkOutput("t1_cnt", 32'(bus_msb.bit_cnt), 32'(8 - i));
    end
    checkOutput("t1_valid_early", 32'(bus_msb.dout_valid), 32'd0);
    applyStimulus(1'b0, stream[0], 1'b1, 1'b0, 1'b1);
    checkMsb("t1", 8'h1F, 1'b1, 3'd0, 1'b0);
    checkLsb("t1", 8'hF8, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_drain", 32'(bus_msb.dout_valid), 32'd0);
    checkOutput("t1_drain_lsb", 32'(bus_lsb.dout_valid), 32'd0);

    // Same stream with a three-cycle gap after the fourth bit
    for (int i = 7; i >= 4; i--) begin
      applyStimulus(1'b0, stream[i], 1'b1, 1'b0, 1'b1);
    end
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("t2_gap_cnt", 32'(bus_lsb.bit_cnt), 32'd4);
    end
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b0, stream[i], 1'b1, 1'b0, 1'b1);
    end
    checkLsb("t2", 8'hF8, 1'b1, 3'd0, 1'b0);
    checkMsb("t2", 8'h1F, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: second word is dropped and flagged once
    sendWord(8'hA5, 1'b0, 1'b0);
    checkMsb("t3_first", 8'hA5, 1'b1, 3'd0, 1'b0);
    for (int i = 7; i >= 1; i--) begin
      applyStimulus(1'b0, stream[i] ^ 1'b1, 1'b1, 1'b0, 1'b0);
    end
    stream = 8'h3C;
    // Note: the 7 bits above are placeholders; resend 3C cleanly below
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkMsb("t3_rst", 8'h00, 1'b0, 3'd0, 1'b0);
    sendWord(8'hA5, 1'b0, 1'b0);
    sendWord(8'h3C, 1'b0, 1'b0);
    checkMsb("t3_over", 8'hA5, 1'b1, 3'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkMsb("t3_pulse", 8'hA5, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_drain", 32'(bus_msb.dout_valid), 32'd0);

    // Load and drain in the same cycle
    sendWord(8'h11, 1'b0, 1'b0);
    checkMsb("t4_first", 8'h11, 1'b1, 3'd0, 1'b0);
    sendWord(8'h22, 1'b0, 1'b1);
    checkMsb("t4", 8'h22, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_drain", 32'(bus_msb.dout_valid), 32'd0);

    // Five garbage bits, then realign with start on the first bit of C3
    stream = 8'b1011_0000;
    for (int i = 7; i >= 3; i--) begin
      applyStimulus(1'b0, stream[i], 1'b1, 1'b0, 1'b1);
    end
    checkOutput("t5_garbage_cnt", 32'(bus_msb.bit_cnt), 32'd5);
    stream = 8'hC3;
    applyStimulus(1'b0, stream[7], 1'b1, 1'b1, 1'b1);
    checkOutput("t5_start_cnt", 32'(bus_msb.bit_cnt), 32'd1);
    for (int i = 6; i >= 0; i--) begin
      applyStimulus(1'b0, stream[i], 1'b1, 1'b0, 1'b1);
    end
    checkMsb("t5", 8'hC3, 1'b1, 3'd0, 1'b0);
    checkLsb("t5", 8'hC3, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Start without a valid bit clears the partial word
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t5b_cnt", 32'(bus_msb.bit_cnt), 32'd0);
    sendWord(8'h0F, 1'b1, 1'b1);
    checkMsb("t5b", 8'h0F, 1'b1, 3'd0, 1'b0);
    checkLsb("t5b", 8'hF0, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame with a held word pending
    sendWord(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    checkMsb("t6_pre", 8'h5A, 1'b1, 3'd4, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkMsb("t6_rst", 8'h00, 1'b0, 3'd0, 1'b0);
    checkLsb("t6_rst", 8'h00, 1'b0, 3'd0, 1'b0);
    sendWord(8'h96, 1'b1, 1'b1);
    checkMsb("t6", 8'h96, 1'b1, 3'd0, 1'b0);
    checkLsb("t6", 8'h69, 1'b1, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
